regfile_dump_ctrl: RTL and testbench

- Sequences a full architectural-register snapshot out of the integer register file, one register per beat.
- Shares one register-file read port between the core (priority requester) and the snapshot scanner.
- Streams {index, value} beats over a valid/ready interface to the simulation checker that consumes register state per commit.
- Sits between the register file's spare read port and the difftest/DPI sink.

---
 rtl/reg_dump_pkg.sv | 27 ++
 rtl/regfile_dump_ctrl_if.sv | 14 +
 rtl/reg_dump_obuf.sv | 34 +++
 rtl/regfile_dump_ctrl.sv | 105 ++++++++++
 tb/tb_regfile_dump_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dump_pkg.sv
// Shared constants, FSM state and beat payload for the register-file snapshot dumper.
// REG_DUMP_SKIP_X0_EN: when defined, the scan starts at x1 and x0 is never emitted.
package reg_dump_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned IDX_W    = $clog2(NUM_REGS);

`ifdef REG_DUMP_SKIP_X0_EN
   localparam int unsigned FIRST_IDX = 1;
`else
   localparam int unsigned FIRST_IDX = 0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  data;
      logic             last;
   } beat_t;

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Valid/ready stream of {index, value, last} beats toward the snapshot sink.
interface regfile_dump_ctrl_if;
   import reg_dump_pkg::*;

   logic             valid;
   logic             ready;
   logic [IDX_W-1:0] idx;
   logic [XLEN-1:0]  data;
   logic             last;

   modport master (output valid, output idx, output data, output last, input ready);
   modport slave  (input valid, input idx, input data, input last, output ready);

endinterface

// File: rtl/reg_dump_obuf.sv
// Single-entry output register; contents stay frozen while valid and not accepted.
module reg_dump_obuf
   import reg_dump_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_load,
   input  beat_t i_beat,
   input  logic  i_ready,
   output logic  o_valid,
   output beat_t o_beat
);

   logic  r_valid;
   beat_t r_beat;

   // Load wins; otherwise an accepted beat empties the entry and drops last.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_beat  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_beat  <= i_beat;
      end else if (r_valid && i_ready) begin
         r_valid     <= 1'b0;
         r_beat.last <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_beat  = r_beat;

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Snapshot scanner sharing the register file's spare read port with the core.
// The core always wins the port; the scan advances only in free cycles with room downstream.
// REG_DUMP_SKIP_X0_EN (optional): scan x1..x(N-1) instead of x0..x(N-1).
module regfile_dump_ctrl
   import reg_dump_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 snap_req,
   output logic                 snap_busy,
   output logic                 snap_drop,
   output logic                 snap_done,
   input  logic                 core_rd_req,
   input  logic [IDX_W-1:0]     core_rd_addr,
   output logic                 core_rd_grant,
   output logic [IDX_W-1:0]     rf_raddr,
   input  logic [XLEN-1:0]      rf_rdata,
   regfile_dump_ctrl_if.master  dump
);

   localparam logic [IDX_W-1:0] W_FIRST = IDX_W'(FIRST_IDX);
   localparam logic [IDX_W-1:0] W_LAST  = IDX_W'(NUM_REGS - 1);

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_scan_idx, w_scan_idx_nxt;
   logic             r_snap_done, w_done_nxt;
   logic             w_load;
   beat_t            w_beat_in;
   beat_t            w_obuf_beat;
   logic             w_obuf_valid;

   // State, scan index and done pulse registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_scan_idx  <= W_FIRST;
         r_snap_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_scan_idx  <= w_scan_idx_nxt;
         r_snap_done <= w_done_nxt;
      end
   end

   // Next-state, index advance and buffer load decisions.
   always_comb begin
      w_state_nxt    = r_state;
      w_scan_idx_nxt = r_scan_idx;
      w_load         = 1'b0;
      w_done_nxt     = 1'b0;
      w_beat_in      = '0;
      w_beat_in.idx  = r_scan_idx;
      // x0 is hardwired to zero architecturally, so never trust the read port for it.
      w_beat_in.data = (r_scan_idx == '0) ? '0 : rf_rdata;
      w_beat_in.last = (r_scan_idx == W_LAST);
      case (r_state)
         IDLE: begin
            if (snap_req) begin
               w_state_nxt    = SCAN;
               w_scan_idx_nxt = W_FIRST;
            end
         end
         SCAN: begin
            if (!core_rd_req && (!w_obuf_valid || dump.ready)) begin
               w_load = 1'b1;
               if (r_scan_idx == W_LAST) begin
                  w_state_nxt = DRAIN;
               end else begin
                  w_scan_idx_nxt = r_scan_idx + IDX_W'(1);
               end
            end
         end
         DRAIN: begin
            if (w_obuf_valid && dump.ready) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output holding register toward the sink.
   reg_dump_obuf u_obuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_beat  (w_beat_in),
      .i_ready (dump.ready),
      .o_valid (w_obuf_valid),
      .o_beat  (w_obuf_beat)
   );

   assign dump.valid    = w_obuf_valid;
   assign dump.idx      = w_obuf_beat.idx;
   assign dump.data     = w_obuf_beat.data;
   assign dump.last     = w_obuf_beat.last;

   assign snap_busy     = (r_state != IDLE);
   assign snap_drop     = snap_req && (r_state != IDLE);
   assign snap_done     = r_snap_done;
   assign core_rd_grant = core_rd_req;
   assign rf_raddr      = core_rd_req ? core_rd_addr : r_scan_idx;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl against a beat-list reference model.
module tb_regfile_dump_ctrl;

   localparam int NREG = 32;
   localparam int IW   = 5;
   localparam int XW   = 64;
`ifdef REG_DUMP_SKIP_X0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int NBEATS = NREG - FIRST;

   typedef struct {
      int          idx;
      logic [XW-1:0] data;
      bit          last;
   } tb_beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          snap_req = 1'b0;
   logic          core_rd_req = 1'b0;
   logic [IW-1:0] core_rd_addr = '0;
   logic          snap_busy, snap_drop, snap_done, core_rd_grant;
   logic [IW-1:0] rf_raddr;
   logic [XW-1:0] rf_rdata;
   logic [XW-1:0] rf_mem [NREG];

   regfile_dump_ctrl_if dump_if();

   assign rf_rdata = rf_mem[rf_raddr];

   regfile_dump_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .snap_req      (snap_req),
      .snap_busy     (snap_busy),
      .snap_drop     (snap_drop),
      .snap_done     (snap_done),
      .core_rd_req   (core_rd_req),
      .core_rd_addr  (core_rd_addr),
      .core_rd_grant (core_rd_grant),
      .rf_raddr      (rf_raddr),
      .rf_rdata      (rf_rdata),
      .dump          (dump_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   tb_beat_t got_q[$];
   tb_beat_t exp_q[$];
   int first_valid_k, done_k, last_acc_k, n_done, n_drop, unstable, grant_err, busy_after;
   bit timed_out;

   // Reference: one beat per scanned register, x0 reads as zero, last flag on the top register.
   function automatic void build_expected();
      exp_q.delete();
      for (int i = FIRST; i < NREG; i++) begin
         tb_beat_t b;
         b.idx  = i;
         b.data = (i == 0) ? 64'd0 : rf_mem[i];
         b.last = (i == NREG - 1);
         exp_q.push_back(b);
      end
   endfunction

   // Index of first differing beat, -2 on length mismatch, -1 when identical.
   function automatic int first_bad_beat();
      if (got_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i])
         if (got_q[i].idx != exp_q[i].idx || got_q[i].data !== exp_q[i].data ||
             got_q[i].last != exp_q[i].last) return i;
      return -1;
   endfunction

   function automatic void fill_seq();
      for (int i = 0; i < NREG; i++) rf_mem[i] = 64'h1000 + 64'(i);
      rf_mem[0] = 64'hDEAD_BEEF_0000_0001;
   endfunction

   function automatic void fill_rand();
      for (int i = 0; i < NREG; i++) rf_mem[i] = {$urandom(), $urandom()};
   endfunction

   // Drives one snapshot with a stimulus pattern and records what the sink sees.
   // mode 0: plain, 1: ready 1,0,0 pattern, 2: core owns port for cycles 3..7,
   // 3: extra requests mid-scan and at drain completion, 4: random ready/core.
   task automatic run_snap(input int mode);
      bit pv = 0, pr = 0, plast = 0;
      int pidx = 0;
      logic [XW-1:0] pdata = '0;
      int k = 0;
      int stop_k = -1;
      bit core, rdy, req, peek_last;
      got_q.delete();
      first_valid_k = -1; done_k = -1; last_acc_k = -1; n_done = 0; n_drop = 0;
      unstable = 0; grant_err = 0; busy_after = 0; timed_out = 0;
      while (1) begin
         @(posedge clk); #1;
         peek_last = (dump_if.valid === 1'b1) && (dump_if.last === 1'b1);
         req  = (k == 0);
         rdy  = 1;
         core = 0;
         core_rd_addr = IW'($urandom_range(0, NREG - 1));
         case (mode)
            1: rdy = (k % 3 == 0);
            2: begin core = (k >= 3 && k <= 7); if (core) core_rd_addr = IW'(5); end
            3: req = (k == 0) || (k == 10) || peek_last;
            4: begin rdy = 1'($urandom_range(0, 1)); core = ($urandom_range(0, 3) == 0); end
            default: ;
         endcase
         snap_req = req; core_rd_req = core; dump_if.ready = rdy;
         #1;
         if (dump_if.valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
         if (pv && !pr && (dump_if.valid !== 1'b1 || int'(dump_if.idx) != pidx ||
             dump_if.data !== pdata || dump_if.last !== plast)) unstable++;
         if (snap_drop === 1'b1) n_drop++;
         if (core ? (core_rd_grant !== 1'b1 || rf_raddr !== core_rd_addr) : (core_rd_grant !== 1'b0))
            grant_err++;
         if (snap_done === 1'b1) begin
            n_done++;
            if (done_k < 0) begin done_k = k; stop_k = k + 3; end
         end
         if (done_k >= 0 && snap_busy !== 1'b0) busy_after++;
         if (dump_if.valid === 1'b1 && rdy) begin
            tb_beat_t b;
            b.idx = int'(dump_if.idx); b.data = dump_if.data; b.last = (dump_if.last === 1'b1);
            got_q.push_back(b);
            if (b.last) last_acc_k = k;
         end
         pv = (dump_if.valid === 1'b1); pr = rdy; pidx = int'(dump_if.idx);
         pdata = dump_if.data; plast = (dump_if.last === 1'b1);
         if (k == stop_k) break;
         if (k >= 600) begin timed_out = 1; break; end
         k++;
      end
      snap_req = 0; core_rd_req = 0; dump_if.ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (dump_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dump_if.valid); end
      n_checks++; if (dump_if.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", dump_if.last); end
      n_checks++; if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", snap_busy); end
      n_checks++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", snap_done); end
      n_checks++; if (snap_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", snap_drop); end
      n_checks++; if (dump_if.idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", dump_if.idx); end
      n_checks++; if (dump_if.data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", dump_if.data); end
      rst_n = 1;
   endtask

   task automatic test_basic_scan();
      int bad;
      fill_seq(); build_expected();
      run_snap(0);
      bad = first_bad_beat();
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got no snap_done expected one within budget"); end
      n_checks++; if (bad !== -1) begin n_fail++; $display("FAIL basic_beats: got %0d beats (first bad %0d) expected %0d", got_q.size(), bad, exp_q.size()); end
      n_checks++; if (first_valid_k !== 2) begin n_fail++; $display("FAIL basic_latency: got cycle %0d expected 2", first_valid_k); end
      n_checks++; if (done_k !== NBEATS + 2) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_k, NBEATS + 2); end
      n_checks++; if (done_k !== last_acc_k + 1) begin n_fail++; $display("FAIL basic_done_after_last: got %0d expected %0d", done_k, last_acc_k + 1); end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
      n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL basic_busy_clear: got %0d busy cycles expected 0", busy_after); end
      n_checks++; if (n_drop !== 0) begin n_fail++; $display("FAIL basic_drop: got %0d expected 0", n_drop); end
   endtask

   task automatic test_backpressure();
      int bad, non_asc;
      fill_rand(); build_expected();
      run_snap(1);
      bad = first_bad_beat();
      non_asc = 0;
      for (int i = 1; i < got_q.size(); i++) if (got_q[i].idx <= got_q[i-1].idx) non_asc++;
      n_checks++; if (bad !== -1 || timed_out) begin n_fail++; $display("FAIL bp_beats: got %0d beats (first bad %0d, timeout %0d) expected %0d", got_q.size(), bad, timed_out, exp_q.size()); end
      n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
      n_checks++; if (non_asc !== 0) begin n_fail++; $display("FAIL bp_ascending: got %0d out-of-order beats expected 0", non_asc); end
      n_checks++; if (done_k !== last_acc_k + 1 || n_done !== 1) begin n_fail++; $display("FAIL bp_done: got cycle %0d count %0d expected cycle %0d count 1", done_k, n_done, last_acc_k + 1); end
   endtask

   task automatic test_core_contention();
      int bad;
      fill_seq(); build_expected();
      run_snap(2);
      bad = first_bad_beat();
      n_checks++; if (grant_err !== 0) begin n_fail++; $display("FAIL core_grant_addr: got %0d bad cycles expected 0", grant_err); end
      n_checks++; if (bad !== -1 || timed_out) begin n_fail++; $display("FAIL core_beats: got %0d beats (first bad %0d) expected %0d", got_q.size(), bad, exp_q.size()); end
      n_checks++; if (done_k !== NBEATS + 2 + 5) begin n_fail++; $display("FAIL core_stall: got done cycle %0d expected %0d", done_k, NBEATS + 7); end
   endtask

   task automatic test_overlap();
      int bad;
      fill_rand(); build_expected();
      run_snap(3);
      bad = first_bad_beat();
      n_checks++; if (n_drop !== 2) begin n_fail++; $display("FAIL overlap_drop: got %0d drops expected 2", n_drop); end
      n_checks++; if (bad !== -1 || timed_out) begin n_fail++; $display("FAIL overlap_beats: got %0d beats (first bad %0d) expected %0d", got_q.size(), bad, exp_q.size()); end
      n_checks++; if (n_done !== 1 || busy_after !== 0) begin n_fail++; $display("FAIL overlap_single: got done %0d busy_after %0d expected 1 and 0", n_done, busy_after); end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      int bad;
      bit hit = 0;
      int late_done = 0, late_busy = 0;
      fill_rand(); build_expected();
      while (!hit && k < 200) begin
         @(posedge clk); #1;
         if (dump_if.valid === 1'b1 && dump_if.idx === IW'(10)) begin rst_n = 0; hit = 1; end
         snap_req = (k == 0); dump_if.ready = 1; core_rd_req = 0;
         k++;
      end
      n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach: got no beat 10 within %0d cycles expected one", k); end
      @(posedge clk); #1;
      rst_n = 1; snap_req = 0;
      #1;
      n_checks++; if (dump_if.valid !== 1'b0 || snap_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: got valid %b busy %b expected 0 0", dump_if.valid, snap_busy); end
      n_checks++; if (snap_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", snap_done); end
      repeat (4) begin
         @(posedge clk); #1;
         if (snap_done !== 1'b0) late_done++;
         if (snap_busy !== 1'b0) late_busy++;
      end
      n_checks++; if (late_done !== 0 || late_busy !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got done %0d busy %0d expected 0 0", late_done, late_busy); end
      dump_if.ready = 0;
      run_snap(0);
      bad = first_bad_beat();
      n_checks++; if (got_q.size() == 0 || got_q[0].idx != FIRST) begin n_fail++; $display("FAIL rstmid_restart_idx: got size %0d expected first idx %0d", got_q.size(), FIRST); end
      n_checks++; if (bad !== -1 || n_done !== 1) begin n_fail++; $display("FAIL rstmid_restart_beats: got %0d beats (first bad %0d) done %0d expected %0d beats done 1", got_q.size(), bad, n_done, exp_q.size()); end
   endtask

   task automatic test_random();
      int bad;
      for (int it = 0; it < 3; it++) begin
         fill_rand(); build_expected();
         run_snap(4);
         bad = first_bad_beat();
         n_checks++; if (bad !== -1 || timed_out) begin n_fail++; $display("FAIL rand_beats[%0d]: got %0d beats (first bad %0d, timeout %0d) expected %0d", it, got_q.size(), bad, timed_out, exp_q.size()); end
         n_checks++; if (unstable !== 0 || grant_err !== 0) begin n_fail++; $display("FAIL rand_protocol[%0d]: got unstable %0d grant errors %0d expected 0 0", it, unstable, grant_err); end
         n_checks++; if (done_k !== last_acc_k + 1 || n_done !== 1) begin n_fail++; $display("FAIL rand_done[%0d]: got cycle %0d count %0d expected cycle %0d count 1", it, done_k, n_done, last_acc_k + 1); end
      end
   endtask

   initial begin
      dump_if.ready = 1'b0;
      fill_seq();
      test_reset();
      test_basic_scan();
      test_backpressure();
      test_core_contention();
      test_overlap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
